// File: rtl/gc_seq_pkg.sv
// Shared types for the garbled-circuit round sequencer: FSM states and run error codes.
package gc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_ABORT   = 2'b10
  } err_t;

  // States in which a run is in progress and abort is honoured.
  function automatic logic is_busy(input state_t s);
    return (s == LAUNCH) || (s == WAIT) || (s == NEXT);
  endfunction

endpackage

// File: rtl/gc_done_collector.sv
// Sticky per-core done mask; all_done_c also counts pulses arriving this cycle.
module gc_done_collector #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         upd,
  input  logic [N-1:0] en_mask,
  input  logic [N-1:0] done_in,
  output logic         all_done_c
);

  logic [N-1:0] seen_q, seen_d;

  always_comb begin
    seen_d = seen_q;
    if (clr) begin
      seen_d = '0;
    end else if (upd) begin
      seen_d = seen_q | (done_in & en_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= '0;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign all_done_c = ((seen_q | (done_in & en_mask)) == en_mask);

endmodule

// File: rtl/gc_round_sequencer.sv
// Run controller: launches N GC cores for num_cc rounds, with masking, timeout and abort.
module gc_round_sequencer
  import gc_seq_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned CC_W    = 16,
  parameter int unsigned TO_W    = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CC_W-1:0]    num_cc,
  input  logic [N_CORES-1:0] core_en,
  input  logic               is_evaluator,
  input  logic [TO_W-1:0]    timeout_lim,
  input  logic               abort,
  input  logic [N_CORES-1:0] core_done,
  output logic [N_CORES-1:0] core_start,
  output logic               core_mode,
  output logic [CC_W-1:0]    cc_idx,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err_code
);

  state_t             state_q, state_d;
  logic [CC_W-1:0]    num_cc_q, num_cc_d;
  logic [N_CORES-1:0] en_q, en_d;
  logic               mode_q, mode_d;
  logic [TO_W-1:0]    lim_q, lim_d;
  logic [TO_W-1:0]    timer_q, timer_d;
  logic [CC_W-1:0]    cc_idx_q, cc_idx_d;
  err_t               err_q, err_d;
  logic [N_CORES-1:0] core_start_q, core_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               clr_c, upd_c, all_done_c;

  gc_done_collector #(.N(N_CORES)) u_collector (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_c),
    .upd        (upd_c),
    .en_mask    (en_q),
    .done_in    (core_done),
    .all_done_c (all_done_c)
  );

  // Next-state, config latching, round/timer arithmetic and registered outputs.
  always_comb begin
    state_d  = state_q;
    num_cc_d = num_cc_q;
    en_d     = en_q;
    mode_d   = mode_q;
    lim_d    = lim_q;
    timer_d  = timer_q;
    cc_idx_d = cc_idx_q;
    err_d    = err_q;
    clr_c    = 1'b0;
    upd_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_cc_d = num_cc;
          en_d     = core_en;
          mode_d   = is_evaluator;
          lim_d    = timeout_lim;
          cc_idx_d = '0;
          err_d    = ERR_NONE;
          state_d  = ((num_cc == '0) || (core_en == '0)) ? FINISH : LAUNCH;
        end
      end
      LAUNCH: begin
        clr_c   = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        upd_c   = 1'b1;
        timer_d = (timer_q == '1) ? timer_q : timer_q + TO_W'(1);
        if (all_done_c) begin
          state_d = (cc_idx_q == num_cc_q - CC_W'(1)) ? FINISH : NEXT;
        end else if ((lim_q != '0) && (timer_q == lim_q - TO_W'(1))) begin
          state_d = FINISH;
          err_d   = ERR_TIMEOUT;
        end
      end
      NEXT: begin
        cc_idx_d = cc_idx_q + CC_W'(1);
        state_d  = LAUNCH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides completion and timeout; the round index is frozen where it stood.
    if (abort && is_busy(state_q)) begin
      state_d  = FINISH;
      err_d    = ERR_ABORT;
      cc_idx_d = cc_idx_q;
    end

    core_start_d = (state_d == LAUNCH) ? en_d : '0;
    busy_d       = is_busy(state_d);
    done_d       = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_cc_q     <= '0;
      en_q         <= '0;
      mode_q       <= 1'b0;
      lim_q        <= '0;
      timer_q      <= '0;
      cc_idx_q     <= '0;
      err_q        <= ERR_NONE;
      core_start_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_cc_q     <= num_cc_d;
      en_q         <= en_d;
      mode_q       <= mode_d;
      lim_q        <= lim_d;
      timer_q      <= timer_d;
      cc_idx_q     <= cc_idx_d;
      err_q        <= err_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign core_start = core_start_q;
  assign core_mode  = mode_q;
  assign cc_idx     = cc_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_code   = err_q;

endmodule
